// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================
// mips_pkg : shared types and constants for the fetch stage
// Rev 1.0
// ============================================================
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================
// if_skid_buf : one-entry {pc, instr} buffer, load/drain/clear
// Rev 1.0
// ============================================================
module if_skid_buf
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_instr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_instr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else begin
      if (i_clear || i_drain) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end
      if (i_load) begin
        r_pc    <= i_pc;
        r_instr <= i_instr;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================
// if_fetch_stage : PC owner, imem req/ack fetch, stall/redirect
// Rev 1.0
// ============================================================
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [ADDR_W-1:0] o_if_pc4,
  output logic [31:0]       o_if_instr,
  output logic              o_if_valid
);

  localparam logic [ADDR_W-1:0] c_word_step  = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] c_align_mask = ADDR_W'(WORD_BYTES - 1);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_addr, r_if_pc, r_if_pc4;
  logic [31:0]       r_if_instr;
  logic              r_req, r_squash, r_if_valid;

  logic [ADDR_W-1:0] w_pc_nxt, w_addr_nxt, w_if_pc_nxt, w_if_pc4_nxt, w_tgt;
  logic [31:0]       w_if_instr_nxt;
  logic              w_squash_nxt, w_if_valid_nxt, w_ack, w_free;
  logic              w_skid_load, w_skid_drain, w_skid_clear, w_skid_valid;
  logic [ADDR_W-1:0] w_skid_pc;
  logic [31:0]       w_skid_instr;

  assign w_ack  = i_imem_ack && r_req;
  assign w_free = !(r_if_valid && i_stall);
  assign w_tgt  = i_redirect_pc & ~c_align_mask;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = FETCH;
      FETCH:   if (!i_redirect && w_ack && !r_squash && !w_free) w_state_nxt = HOLD;
      HOLD:    if (i_redirect || w_free) w_state_nxt = FETCH;
      default: w_state_nxt = BOOT;
    endcase
  end

  // r_pc holds the pending redirect target while a squashed request drains
  always_comb begin
    w_pc_nxt       = r_pc;
    w_addr_nxt     = r_addr;
    w_squash_nxt   = r_squash;
    w_if_pc_nxt    = r_if_pc;
    w_if_pc4_nxt   = r_if_pc4;
    w_if_instr_nxt = r_if_instr;
    w_if_valid_nxt = r_if_valid;
    w_skid_load    = 1'b0;
    w_skid_drain   = 1'b0;
    w_skid_clear   = 1'b0;
    case (r_state)
      BOOT: begin
        if (i_redirect) begin
          w_pc_nxt       = w_tgt;
          w_addr_nxt     = w_tgt;
          w_if_valid_nxt = 1'b0;
          w_if_instr_nxt = NOP_INSTR;
        end else begin
          w_addr_nxt = r_pc;
        end
      end
      FETCH: begin
        if (i_redirect) begin
          w_pc_nxt       = w_tgt;
          w_if_valid_nxt = 1'b0;
          w_if_instr_nxt = NOP_INSTR;
          if (w_ack) begin
            w_addr_nxt   = w_tgt;
            w_squash_nxt = 1'b0;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end else if (w_ack && r_squash) begin
          w_addr_nxt   = r_pc;
          w_squash_nxt = 1'b0;
        end else if (w_ack && w_free) begin
          w_if_pc_nxt    = r_addr;
          w_if_pc4_nxt   = r_addr + c_word_step;
          w_if_instr_nxt = i_imem_rdata;
          w_if_valid_nxt = 1'b1;
          w_addr_nxt     = r_addr + c_word_step;
        end else if (w_ack) begin
          w_skid_load = 1'b1;
        end else if (w_free) begin
          w_if_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          w_skid_clear   = 1'b1;
          w_pc_nxt       = w_tgt;
          w_addr_nxt     = w_tgt;
          w_squash_nxt   = 1'b0;
          w_if_valid_nxt = 1'b0;
          w_if_instr_nxt = NOP_INSTR;
        end else if (w_free) begin
          w_skid_drain   = 1'b1;
          w_if_pc_nxt    = w_skid_pc;
          w_if_pc4_nxt   = w_skid_pc + c_word_step;
          w_if_instr_nxt = w_skid_instr;
          w_if_valid_nxt = w_skid_valid;
          w_addr_nxt     = w_skid_pc + c_word_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_squash   <= 1'b0;
      r_if_pc    <= RESET_PC;
      r_if_pc4   <= RESET_PC + c_word_step;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= (w_state_nxt == FETCH);
      r_squash   <= w_squash_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_valid <= w_if_valid_nxt;
    end
  end

  if_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (w_skid_clear),
    .i_pc    (r_addr),
    .i_instr (i_imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_addr;
  assign o_if_pc     = r_if_pc;
  assign o_if_pc4    = r_if_pc4;
  assign o_if_instr  = r_if_instr;
  assign o_if_valid  = r_if_valid;

endmodule
`default_nettype wire
